// File: rtl/wave_pkg.sv
// Shared definitions for the waveform generator DAC output path.
package wave_pkg;

  localparam int unsigned FRAME_W     = 16;
  localparam logic [3:0]  DEFAULT_CMD = 4'b0011;

  // SPI frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } dac_state_e;

  // Round to nearest, saturate to dac_w bits, convert to offset binary.
  function automatic logic [14:0] dac_code(input logic [15:0] sample,
                                           input int unsigned dac_w);
    int r;
    int s;
    int lim;
    r   = 32'($signed(sample));
    r   = r + (1 << (15 - dac_w));
    s   = r >>> (16 - dac_w);
    lim = 1 << (dac_w - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim)    s = -lim;
    return 15'(s + lim);
  endfunction

endpackage

// File: rtl/dac_spi_tx_sample_tick.sv
// Programmable sample-rate divider: one-cycle tick every sample_div cycles.
module sample_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] sample_div,
  output logic        tick_c
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        run_c;

  assign run_c  = enable && (sample_div != 16'd0);
  assign tick_c = run_c && (cnt_q >= sample_div - 16'd1);

  // Next count: hold at zero when idle, wrap after the tick
  always_comb begin
    cnt_d = cnt_q;
    if (!run_c || tick_c) cnt_d = 16'd0;
    else                  cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Decimating sample-to-DAC SPI transmitter with one-entry holding register.
// Optional macro DAC_LDAC_EN adds an ldac_n strobe after each frame.
module dac_spi_tx
  import wave_pkg::*;
#(
  parameter int unsigned DAC_W    = 12,
  parameter int unsigned SCLK_DIV = 2,
  parameter logic [3:0]  CMD      = DEFAULT_CMD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic [15:0] sample_div,
  input  logic        enable,
  input  logic        clr_overrun,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_cs_n,
  output logic        busy,
`ifdef DAC_LDAC_EN
  output logic        ldac_n,
`endif
  output logic        overrun
);

  localparam int unsigned PAD_W = FRAME_W - 4 - DAC_W;
  localparam int unsigned CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  dac_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               overrun_q, overrun_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
`ifdef DAC_LDAC_EN
  logic               ldac_n_q, ldac_n_d;
`endif

  logic               tick_c;
  logic               load_c;
  logic               drop_c;
  logic               cnt_last_c;
  logic [14:0]        code_c;
  logic [FRAME_W-1:0] frame_c;

  sample_tick u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sample_div (sample_div),
    .tick_c     (tick_c)
  );

  // Frame image of the current sample: command, code, zero padding
  assign code_c     = dac_code(sample_in, DAC_W);
  assign frame_c    = FRAME_W'({CMD, DAC_W'(code_c)}) << PAD_W;
  assign load_c     = (state_q == ST_IDLE) && hold_valid_q;
  assign drop_c     = tick_c && hold_valid_q && !load_c;
  assign cnt_last_c = (cnt_q == CNT_W'(SCLK_DIV - 1));

  // Next state, bit timing, shift register, holding register and overrun
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;

    if (load_c) hold_valid_d = 1'b0;
    if (tick_c && !drop_c) begin
      hold_d       = frame_c;
      hold_valid_d = 1'b1;
    end
    if (drop_c)           overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          shift_d = hold_q;
        end
      end
      ST_SETUP: begin
        if (cnt_last_c) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd0;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_last_c) begin
          cnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            shift_d = shift_q << 1;
          end else if (bit_q == 4'd15) begin
            state_d = ST_GAP;
          end else begin
            phase_d = 1'b1;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_last_c) begin
          cnt_d = '0;
`ifdef DAC_LDAC_EN
          state_d = ST_LDAC;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LDAC: begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the upcoming state, so registered pins track the FSM
  always_comb begin
    cs_n_d = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
`ifdef DAC_LDAC_EN
    ldac_n_d = 1'b1;
`endif
    case (state_d)
      ST_SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = shift_d[FRAME_W-1];
      end
      ST_SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = phase_d;
        mosi_d = shift_d[FRAME_W-1];
      end
`ifdef DAC_LDAC_EN
      ST_LDAC: ldac_n_d = 1'b0;
`endif
      default: ;
    endcase
  end

  // State, datapath and pin registers; reset aborts any frame immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      phase_q      <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_n_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
`ifdef DAC_LDAC_EN
      ldac_n_q     <= ldac_n_d;
`endif
    end
  end

  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_mosi = mosi_q;
  assign overrun  = overrun_q;
  // Busy also covers the IDLE cycle in which a pending frame is launched
  assign busy     = (state_q != ST_IDLE) || hold_valid_q;
`ifdef DAC_LDAC_EN
  assign ldac_n   = ldac_n_q;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx (DAC_W=12, SCLK_DIV=2, CMD=4'b0011).
module tb_dac_spi_tx;

  typedef struct {
    logic [15:0] data;
    int          nb;
    int          low;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic [15:0] sample_div;
  logic        enable;
  logic        clr_overrun;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        dac_cs_n;
  logic        busy;
  logic        overrun;
`ifdef DAC_LDAC_EN
  logic        ldac_n;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int rd_idx      = 0;

  frame_t      frames[$];
  int          mon_nb  = 0;
  int          mon_low = 0;
  logic [15:0] mon_sh  = 16'h0000;
  logic        sclk_prev = 1'b0;
  logic        cs_prev   = 1'b1;

  always #5 clk = ~clk;

  dac_spi_tx dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_div  (sample_div),
    .enable      (enable),
    .clr_overrun (clr_overrun),
    .dac_sclk    (dac_sclk),
    .dac_mosi    (dac_mosi),
    .dac_cs_n    (dac_cs_n),
    .busy        (busy),
`ifdef DAC_LDAC_EN
    .ldac_n      (ldac_n),
`endif
    .overrun     (overrun)
  );

  // SPI receiver model: samples mosi on sclk rise, closes a frame on cs_n rise
  always @(negedge clk) begin
    if (!dac_cs_n) begin
      mon_low = mon_low + 1;
      if (dac_sclk && !sclk_prev) begin
        mon_sh = {mon_sh[14:0], dac_mosi};
        mon_nb = mon_nb + 1;
      end
    end else if (!cs_prev) begin
      frames.push_back('{mon_sh, mon_nb, mon_low});
      mon_sh  = 16'h0000;
      mon_nb  = 0;
      mon_low = 0;
    end
    sclk_prev = dac_sclk;
    cs_prev   = dac_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_frame(input int budget, output frame_t f);
    f = '{16'hxxxx, -1, -1};
    for (int i = 0; i < budget; i++) begin
      if (frames.size() > rd_idx) begin
        f = frames[rd_idx];
        rd_idx++;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic wait_bits(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (mon_nb >= n) break;
    end
    check("bits_reached", 32'(mon_nb), 32'(n));
  endtask

  frame_t f;

  initial begin
    rst         = 1'b0;
    sample_in   = 16'h0000;
    sample_div  = 16'd0;
    enable      = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(dac_cs_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd0);
    check("rst_mosi", 32'(dac_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    // Saturation and rounding vectors, one frame per 200-cycle tick
    sample_in  = 16'h7FFF;
    sample_div = 16'd200;
    @(negedge clk);
    enable = 1'b1;
    get_frame(400, f);
    check("f_7fff", 32'(f.data), 32'h3FFF);
    check("f_7fff_bits", 32'(f.nb), 32'd16);
    check("f_7fff_cs_low", 32'(f.low), 32'd66);
    sample_in = 16'h8000;
    get_frame(400, f);
    check("f_8000", 32'(f.data), 32'h3000);
    sample_in = 16'h0000;
    get_frame(400, f);
    check("f_0000", 32'(f.data), 32'h3800);
    sample_in = 16'h0007;
    get_frame(400, f);
    check("rnd_0007", 32'(f.data[11:0]), 32'h800);
    sample_in = 16'h0008;
    get_frame(400, f);
    check("rnd_0008", 32'(f.data[11:0]), 32'h801);
    sample_in = 16'h7FF8;
    get_frame(400, f);
    check("rnd_7ff8", 32'(f.data[11:0]), 32'hFFF);
    check("rnd_7ff8_bits", 32'(f.nb), 32'd16);
    enable = 1'b0;
    repeat (10) @(negedge clk);

    // Overrun: ticks every 10 cycles, third sample dropped during frame 1
    sample_div = 16'd10;
    sample_in  = 16'h1000;
    enable     = 1'b1;
    repeat (10) @(negedge clk);
    sample_in = 16'hF000;
    repeat (10) @(negedge clk);
    sample_in = 16'h4000;
    repeat (10) @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_in_frame1", 32'(dac_cs_n), 32'd0);
    enable = 1'b0;
    get_frame(300, f);
    check("ovr_first", 32'(f.data), 32'h3900);
    get_frame(300, f);
    check("ovr_second", 32'(f.data), 32'h3700);
    repeat (200) @(negedge clk);
    check("ovr_no_third", 32'(frames.size()), 32'(rd_idx));
    check("ovr_idle_busy", 32'(busy), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset mid-shift at bit 7, then a clean frame
    sample_in  = 16'h0000;
    sample_div = 16'd200;
    enable     = 1'b1;
    wait_bits(8, 600);
    #2;
    rst = 1'b0;
    #1;
    check("abort_cs_n", 32'(dac_cs_n), 32'd1);
    check("abort_sclk", 32'(dac_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sample_in = 16'h0008;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    get_frame(50, f);
    check("abort_partial_bits", 32'(f.nb), 32'd8);
    get_frame(400, f);
    check("post_rst_frame", 32'(f.data), 32'h3801);
    check("post_rst_bits", 32'(f.nb), 32'd16);
    enable = 1'b0;
    repeat (10) @(negedge clk);

    // Enable dropped at bit 3 of frame 1 while the holding register is full
    sample_div = 16'd15;
    sample_in  = 16'h8000;
    enable     = 1'b1;
    repeat (15) @(negedge clk);
    sample_in = 16'h7FF8;
    wait_bits(4, 200);
    @(negedge clk);
    enable = 1'b0;
    get_frame(300, f);
    check("en_drop_first", 32'(f.data), 32'h3000);
    get_frame(300, f);
    check("en_drop_second", 32'(f.data), 32'h3FFF);
    check("en_drop_second_bits", 32'(f.nb), 32'd16);
    repeat (150) @(negedge clk);
    check("en_drop_no_more", 32'(frames.size()), 32'(rd_idx));
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_cs_n", 32'(dac_cs_n), 32'd1);
    check("en_drop_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
